mem_probe_ctrl: RTL and testbench

//  Button-driven probe controller for interleaved_memory on FPGA dev boards.
//  - Debounces and edge-detects board buttons, then issues navigation and write commands to the memory port.
//  - Drives a configurable LED slice of read data.
//  - Replaces ad-hoc level-sensitive button logic with single-cycle write pulses and an explicit command FSM.

---
 rtl/mem_probe_ctrl_if.sv | 37 +++
 rtl/mem_probe_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_mem_probe_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_probe_ctrl_if.sv
// Memory-port bundle between mem_probe_ctrl and the interleaved memory,
// plus the shared access-width type.
package mem_probe_pkg;
  typedef enum logic {
    MEM_BYTE = 1'b0,
    MEM_WORD = 1'b1
  } mem_width_t;
endpackage

interface mem_probe_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  import mem_probe_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  mem_width_t        mem_width;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_width,
    output mem_we,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_width,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_probe_ctrl.sv
// Button-driven probe controller: debounced navigation/write commands, LED view of read data.
// Optional auto-scan address stepping is built only when MEM_PROBE_SCAN_EN is defined.
module mem_probe_ctrl
  import mem_probe_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       LED_W     = 8,
  parameter int unsigned       DB_CYCLES = 65536,
  parameter logic [7:0]        BYTE_PAT  = 8'hA7,
  parameter logic [DATA_W-1:0] WORD_PAT  = 32'h0DEFACED,
  parameter int unsigned       SCAN_DIV  = 2**24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0]       btn_i,
  input  logic             scan_i,
  mem_probe_if.master      mem,
  output logic [LED_W-1:0] led_o,
  output logic             busy_o
);

  localparam int unsigned       DB_W      = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DB_CYCLES - 1);
  localparam logic [DATA_W-1:0] BYTE_WORD = DATA_W'(BYTE_PAT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic [3:0]      sync1_q, sync2_q, last_q;
  logic [3:0]      acc_q, acc_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [DB_W-1:0] db_cnt_q [4];
  logic [DB_W-1:0] db_cnt_d [4];

  // Debounce next state: any change of the synced level restarts the count.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_d[i]    = acc_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] != last_q[i]) begin
        db_cnt_d[i] = {DB_W{1'b0}};
      end else if (db_cnt_q[i] == DB_MAX) begin
        acc_d[i] = last_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1'b1);
      end
    end
    cmd_d = acc_d & ~acc_q;
  end

  // Synchroniser, debounce counters, accepted levels and command pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      last_q  <= 4'b0000;
      acc_q   <= 4'b0000;
      cmd_q   <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= {DB_W{1'b0}};
      end
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      last_q  <= sync2_q;
      acc_q   <= acc_d;
      cmd_q   <= cmd_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-scan (optional)
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] cmd_ok_s;
  logic       scan_step_s;

`ifdef MEM_PROBE_SCAN_EN
  localparam int unsigned     SC_W   = $clog2(SCAN_DIV);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCAN_DIV - 1);

  logic            scan_s1_q, scan_s2_q;
  logic [SC_W-1:0] presc_q, presc_d;
  logic            write_cmd_s;

  // Navigation commands are masked while scanning; writes always go through.
  assign cmd_ok_s    = cmd_q & {2'b11, ~scan_s2_q, ~scan_s2_q};
  assign write_cmd_s = cmd_ok_s[2] | cmd_ok_s[3];

  // Prescaler clears when scan is off and pauses outside IDLE or on a write.
  always_comb begin
    presc_d     = presc_q;
    scan_step_s = 1'b0;
    if (!scan_s2_q) begin
      presc_d = {SC_W{1'b0}};
    end else if ((state_q != ST_IDLE) || write_cmd_s) begin
      presc_d = presc_q;
    end else if (presc_q == SC_MAX) begin
      presc_d     = {SC_W{1'b0}};
      scan_step_s = 1'b1;
    end else begin
      presc_d = presc_q + SC_W'(1'b1);
    end
  end

  // Scan switch synchroniser and prescaler register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_s1_q <= 1'b0;
      scan_s2_q <= 1'b0;
      presc_q   <= {SC_W{1'b0}};
    end else begin
      scan_s1_q <= scan_i;
      scan_s2_q <= scan_s1_q;
      presc_q   <= presc_d;
    end
  end
`else
  logic unused_scan;

  assign unused_scan = scan_i;
  assign cmd_ok_s    = cmd_q;
  assign scan_step_s = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Command FSM and registered outputs
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_q, addr_d;
  mem_width_t        width_q, width_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              unused_rdata;

  assign unused_rdata = ^mem.mem_rdata;

  // Next-state and output decode; command priority is btn0 > btn1 > btn2 > btn3.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    width_d = width_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    led_d   = led_q;
    case (state_q)
      ST_IDLE: begin
        led_d = mem.mem_rdata[LED_W-1:0];
        if (cmd_ok_s[0]) begin
          addr_d = addr_q + ADDR_W'(1'b1);
        end else if (cmd_ok_s[1]) begin
          addr_d = {ADDR_W{1'b0}};
        end else if (cmd_ok_s[2]) begin
          width_d = MEM_BYTE;
          wdata_d = BYTE_WORD;
          we_d    = 1'b1;
          state_d = ST_WRITE;
        end else if (cmd_ok_s[3]) begin
          width_d = MEM_WORD;
          wdata_d = WORD_PAT;
          we_d    = 1'b1;
          state_d = ST_WRITE;
        end else if (scan_step_s) begin
          addr_d = addr_q + ADDR_W'(1'b1);
        end else begin
          addr_d = addr_q;
        end
      end
      ST_WRITE: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        width_d = MEM_BYTE;
        wdata_d = {DATA_W{1'b0}};
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered memory/LED outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      width_q <= MEM_BYTE;
      we_q    <= 1'b0;
      wdata_q <= {DATA_W{1'b0}};
      led_q   <= {LED_W{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      width_q <= width_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      led_q   <= led_d;
    end
  end

  assign mem.mem_addr  = addr_q;
  assign mem.mem_width = width_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_wdata = wdata_q;
  assign led_o         = led_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_probe_ctrl.sv
// Directed bench for mem_probe_ctrl with a 1-cycle-latency memory model.
// The scan sequence is exercised according to MEM_PROBE_SCAN_EN.
module tb_mem_probe_ctrl;
  import mem_probe_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LED_W  = 8;

  typedef struct {
    logic [3:0]  btn;
    int          hold;
    logic [9:0]  exp_addr;
    int          exp_wr;
    logic [31:0] exp_wdata;
    logic        exp_word;
    logic [7:0]  exp_led;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic       scan;
  logic [7:0] led;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  mem_probe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  mem_probe_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LED_W(LED_W),
    .DB_CYCLES(4), .SCAN_DIV(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn), .scan_i(scan),
    .mem(mif), .led_o(led), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Memory model: contents reload on reset, read data registered.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A000000 | 32'(i);
    end else if (mif.mem_we) begin
      if (mif.mem_width == MEM_WORD) mem[mif.mem_addr] <= mif.mem_wdata;
      else mem[mif.mem_addr][7:0] <= mif.mem_wdata[7:0];
    end
    mif.mem_rdata <= mem[mif.mem_addr];
  end

  // Write monitor.
  int          wr_cnt = 0;
  int          pulse_err = 0;
  logic        prev_we = 1'b0;
  logic [31:0] last_wdata = 32'h0;
  logic        last_word = 1'b0;
  logic        last_busy = 1'b0;
  always @(negedge clk) begin
    if (rst_n && mif.mem_we) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= mif.mem_wdata;
      last_word  <= (mif.mem_width == MEM_WORD);
      last_busy  <= busy;
      if (prev_we) pulse_err <= pulse_err + 1;
    end
    prev_we <= rst_n & mif.mem_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic press(input logic [3:0] b, input int hold, input int rel);
    @(negedge clk);
    btn = b;
    repeat (hold) @(negedge clk);
    btn = 4'b0000;
    repeat (rel) @(negedge clk);
  endtask

  vec_t vecs[$];

  task automatic add(input logic [3:0] b, input int h, input logic [9:0] a, input int w,
                     input logic [31:0] wd, input logic wk, input logic [7:0] l);
    vec_t v;
    v.btn = b; v.hold = h; v.exp_addr = a; v.exp_wr = w;
    v.exp_wdata = wd; v.exp_word = wk; v.exp_led = l;
    vecs.push_back(v);
  endtask

  initial begin
    int   wr0;
    bit   seen;
    logic [9:0] a0;

    //      btn      hold addr    wr wdata          word  led
    add(4'b0001, 10,  10'd1, 0, 32'h0,        1'b0, 8'h01);
    add(4'b0001, 10,  10'd2, 0, 32'h0,        1'b0, 8'h02);
    add(4'b0001, 10,  10'd3, 0, 32'h0,        1'b0, 8'h03);
    add(4'b0001, 2,   10'd3, 0, 32'h0,        1'b0, 8'h03);
    add(4'b0001, 200, 10'd4, 0, 32'h0,        1'b0, 8'h04);
    add(4'b0010, 10,  10'd0, 0, 32'h0,        1'b0, 8'h00);
    add(4'b0001, 10,  10'd1, 0, 32'h0,        1'b0, 8'h01);
    add(4'b0001, 10,  10'd2, 0, 32'h0,        1'b0, 8'h02);
    add(4'b0001, 10,  10'd3, 0, 32'h0,        1'b0, 8'h03);
    add(4'b0001, 10,  10'd4, 0, 32'h0,        1'b0, 8'h04);
    add(4'b0001, 10,  10'd5, 0, 32'h0,        1'b0, 8'h05);
    add(4'b0100, 10,  10'd5, 1, 32'h000000A7, 1'b0, 8'hA7);
    add(4'b1000, 10,  10'd5, 1, 32'h0DEFACED, 1'b1, 8'hED);
    add(4'b1001, 10,  10'd6, 0, 32'h0,        1'b0, 8'h06);
    add(4'b0110, 10,  10'd0, 0, 32'h0,        1'b0, 8'h00);

    btn = 4'b0000; scan = 1'b0; rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_addr",  32'(mif.mem_addr),  32'h0);
    check("reset_we",    32'(mif.mem_we),    32'h0);
    check("reset_width", 32'(mif.mem_width), 32'(MEM_BYTE));
    check("reset_wdata", mif.mem_wdata,      32'h0);
    check("reset_led",   32'(led),           32'h0);
    check("reset_busy",  32'(busy),          32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      wr0 = wr_cnt;
      press(vecs[i].btn, vecs[i].hold, 14);
      check($sformatf("v%0d_addr", i), 32'(mif.mem_addr), 32'(vecs[i].exp_addr));
      check($sformatf("v%0d_writes", i), 32'(wr_cnt - wr0), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
      if (vecs[i].exp_wr > 0) begin
        check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
        check($sformatf("v%0d_width", i), 32'(last_word), 32'(vecs[i].exp_word));
        check($sformatf("v%0d_busy_in_write", i), 32'(last_busy), 32'h1);
      end
    end

    // btn0 raised one cycle after btn2 lands its command in WRITE and is dropped.
    wr0 = wr_cnt;
    @(negedge clk) btn = 4'b0100;
    @(negedge clk) btn = 4'b0101;
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    repeat (14) @(negedge clk);
    check("drop_in_write_addr",   32'(mif.mem_addr), 32'h0);
    check("drop_in_write_writes", 32'(wr_cnt - wr0), 32'h1);
    check("we_pulse_width",       32'(pulse_err),    32'h0);

    // Address wrap at the top of the range.
    for (int i = 0; i < 1023; i++) press(4'b0001, 10, 10);
    check("addr_top", 32'(mif.mem_addr), 32'h3FF);
    check("led_top",  32'(led),          32'hFF);
    press(4'b0001, 10, 10);
    check("addr_wrap", 32'(mif.mem_addr), 32'h0);

    // Reset while the write pulse is high.
    press(4'b0001, 10, 14);
    press(4'b0001, 10, 14);
    wr0  = wr_cnt;
    seen = 1'b0;
    @(negedge clk) btn = 4'b1000;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (mif.mem_we) seen = 1'b1;
    end
    check("we_seen_before_reset", 32'(seen), 32'h1);
    btn = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_we",   32'(mif.mem_we),   32'h0);
    check("midreset_addr", 32'(mif.mem_addr), 32'h0);
    check("midreset_busy", 32'(busy),         32'h0);
    check("midreset_led",  32'(led),          32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_writes", 32'(wr_cnt - wr0),   32'h1);
    check("post_reset_addr",   32'(mif.mem_addr),   32'h0);
    check("post_reset_pulse",  32'(pulse_err),      32'h0);

`ifdef MEM_PROBE_SCAN_EN
    a0 = mif.mem_addr;
    scan = 1'b1;
    repeat (40) @(negedge clk);
    check("scan_steps_4_to_5",
          32'((mif.mem_addr - a0 >= 10'd4) && (mif.mem_addr - a0 <= 10'd5)), 32'h1);
    press(4'b0010, 10, 10);
    check("scan_btn1_ignored", 32'(mif.mem_addr - a0 >= 10'd5), 32'h1);
    scan = 1'b0;
    repeat (4) @(negedge clk);
    a0 = mif.mem_addr;
    repeat (30) @(negedge clk);
    check("scan_off_frozen", 32'(mif.mem_addr), 32'(a0));
`else
    a0 = mif.mem_addr;
    scan = 1'b1;
    repeat (40) @(negedge clk);
    check("scan_unused", 32'(mif.mem_addr), 32'(a0));
    scan = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
